// File: rtl/hazard_ctrl_if.sv
// Purpose: signal bundle between the pipeline datapath and the hazard sequencer.
// Latency: wires only; no state in the bundle.
// Backpressure: none here; stall/flush/hold requests travel on the slave-driven outputs.
// Ports: master = pipeline side (drives stage register addresses, control bits, dmem status);
//        slave  = hazard_ctrl (drives enables, flushes, hold, forwarding selects, mem_err, stall_cycles).
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  // ID stage
  logic [4:0]       rs1Addr_id;
  logic [4:0]       rs2Addr_id;
  logic             rs1Used_id;
  logic             rs2Used_id;
  // EX stage
  logic [4:0]       rs1Addr_ex;
  logic [4:0]       rs2Addr_ex;
  logic [4:0]       rdAddr_ex;
  logic             RegWrite_ex;
  logic             MemRead_ex;
  logic             redirect_ex;
  // MEM stage and data memory
  logic [4:0]       rdAddr_mem;
  logic             RegWrite_mem;
  logic             dmem_req_mem;
  logic             dmem_ready;
  // sequencer outputs
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFID_flush;
  logic             IDEX_flush;
  logic             EXMEM_hold;
  logic [1:0]       ForwardA;
  logic [1:0]       ForwardB;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id,
    output rs1Addr_ex, rs2Addr_ex, rdAddr_ex, RegWrite_ex, MemRead_ex, redirect_ex,
    output rdAddr_mem, RegWrite_mem, dmem_req_mem, dmem_ready,
    input  PCWrite, IFIDWrite, IFID_flush, IDEX_flush, EXMEM_hold,
    input  ForwardA, ForwardB, mem_err, stall_cycles
  );

  modport slave (
    input  rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id,
    input  rs1Addr_ex, rs2Addr_ex, rdAddr_ex, RegWrite_ex, MemRead_ex, redirect_ex,
    input  rdAddr_mem, RegWrite_mem, dmem_req_mem, dmem_ready,
    output PCWrite, IFIDWrite, IFID_flush, IDEX_flush, EXMEM_hold,
    output ForwardA, ForwardB, mem_err, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Purpose: pipeline sequencer - load-use/RAW stalls, branch redirect flushes, dmem wait holds, EX forwarding.
// Latency: control outputs combinational in the same cycle; mem_err, stall_cycles and WB tracking registered.
// Backpressure: a dmem wait freezes PC/IF-ID and holds EX/MEM+MEM/WB until dmem_ready; hazards stall PC/IF-ID.
// Ports: clk, rst_n (async active-low) plus hazard_ctrl_if.slave hz carrying all stage inputs and controls.
// Build option: HAZARD_FWD_EN defined enables EX forwarding (only load-use stalls); undefined ties
//   ForwardA/B to 00 and stalls on any RAW against an EX or MEM producer until it reaches WB.
module hazard_ctrl #(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8,
  parameter int CNT_W    = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {
    RUN   = 1'b0,
    MWAIT = 1'b1
  } state_t;

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               mem_err_q;
  logic [CNT_W-1:0]   stall_q;

  logic               mwait;
  logic               ex_raw;
  logic               lduse;
  logic [1:0]         fwd_a, fwd_b;

  logic               pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold;
  logic [1:0]         fwd_a_out, fwd_b_out;

  // True when the ID instruction actually reads architectural register rd (x0 never counts).
  function automatic logic id_reads(input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic used1,
                                    input logic [4:0] rs2, input logic used2);
    return (rd != 5'd0) && ((used1 && (rs1 == rd)) || (used2 && (rs2 == rd)));
  endfunction

  assign mwait  = hz.dmem_req_mem & ~hz.dmem_ready;
  assign ex_raw = hz.RegWrite_ex &
                  id_reads(hz.rdAddr_ex, hz.rs1Addr_id, hz.rs1Used_id, hz.rs2Addr_id, hz.rs2Used_id);

`ifdef HAZARD_FWD_EN
  // Only a load in EX cannot be covered by forwarding.
  assign lduse = ex_raw & hz.MemRead_ex;

  // WB-stage destination, captured from MEM whenever the back end is not held.
  logic [4:0] wb_rd_q;
  logic       wb_we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_rd_q <= 5'd0;
      wb_we_q <= 1'b0;
    end else if (!exmem_hold) begin
      wb_rd_q <= hz.rdAddr_mem;
      wb_we_q <= hz.RegWrite_mem;
    end
  end

  // MEM is the younger producer, so it wins over WB for the same register.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] mem_rd, input logic mem_we,
                                         input logic [4:0] wb_rd,  input logic wb_we);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      sel = 2'b10;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign fwd_a = fwd_sel(hz.rs1Addr_ex, hz.rdAddr_mem, hz.RegWrite_mem, wb_rd_q, wb_we_q);
  assign fwd_b = fwd_sel(hz.rs2Addr_ex, hz.rdAddr_mem, hz.RegWrite_mem, wb_rd_q, wb_we_q);
`else
  // Without bypass paths every in-flight producer must retire to WB before ID may proceed;
  // the stall re-evaluates every cycle as the producer advances.
  logic mem_raw;
  logic unused_fwd;

  assign mem_raw = hz.RegWrite_mem &
                   id_reads(hz.rdAddr_mem, hz.rs1Addr_id, hz.rs1Used_id, hz.rs2Addr_id, hz.rs2Used_id);
  assign lduse      = ex_raw | mem_raw;
  assign fwd_a      = 2'b00;
  assign fwd_b      = 2'b00;
  assign unused_fwd = ^{hz.rs1Addr_ex, hz.rs2Addr_ex, hz.MemRead_ex};
`endif

  // Next state, wait counter and pipeline controls.
  always_comb begin
    state_d    = mwait ? MWAIT : RUN;
    wait_cnt_d = '0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    exmem_hold = 1'b0;
    fwd_a_out  = fwd_a;
    fwd_b_out  = fwd_b;

    // wait_cnt counts waited cycles in the current episode; it restarts at 1 on entry.
    if (state_d == MWAIT) begin
      if (state_q == RUN) begin
        wait_cnt_d = WAIT_W'(1);
      end else if (wait_cnt_q != MAX_CNT) begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end else begin
        wait_cnt_d = wait_cnt_q;
      end
    end

    if (!rst_n) begin
      // Reset presents a fully bubbled, frozen front end.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      fwd_a_out  = 2'b00;
      fwd_b_out  = 2'b00;
    end else if (mwait) begin
      // ID/EX is frozen by the hold itself, so no bubble is inserted.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      exmem_hold = 1'b1;
    end else if (hz.redirect_ex) begin
      // Fetch the target while squashing the two wrong-path instructions.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lduse) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if ((state_d == MWAIT) && (wait_cnt_d == MAX_CNT)) begin
        mem_err_q <= 1'b1;
      end
      if (!pc_write) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign hz.PCWrite      = pc_write;
  assign hz.IFIDWrite    = ifid_write;
  assign hz.IFID_flush   = ifid_flush;
  assign hz.IDEX_flush   = idex_flush;
  assign hz.EXMEM_hold   = exmem_hold;
  assign hz.ForwardA     = fwd_a_out;
  assign hz.ForwardB     = fwd_b_out;
  assign hz.mem_err      = mem_err_q;
  assign hz.stall_cycles = stall_q;

endmodule
